sbqm_param: RTL and testbench

Parametrised, clocked successor to the bank-queue manager. It tracks customers in a queue from two photo-sensor inputs:
- back sensor: arrival
- front sensor: departure

It reports count, full and empty status, and a computed expected waiting time for the current number of open tellers. Adds sensor synchronisation, edge detection, a multi-cycle divider with a valid flag, and reject/underflow flags.

---
 rtl/sbqm_param_if.sv | 28 ++
 rtl/sbqm_param.sv | 202 ++++++++++++++++++++
 tb/tb_sbqm_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sbqm_param_if.sv
// Sensor/teller inputs and queue status outputs of the bank-queue manager.
// The master drives the sensors and the teller count; the slave reports queue state.
interface sbqm_param_if #(
    parameter int N  = 3,
    parameter int TW = 2,
    parameter int WW = 5
) ();
    logic [TW-1:0] tcount;
    logic          backphoto;
    logic          forwardphoto;
    logic [N-1:0]  pcount;
    logic          full;
    logic          empty;
    logic [WW-1:0] wtime;
    logic          wtime_valid;
    logic          reject;
    logic          underflow;

    modport master (
        output tcount, backphoto, forwardphoto,
        input  pcount, full, empty, wtime, wtime_valid, reject, underflow
    );

    modport slave (
        input  tcount, backphoto, forwardphoto,
        output pcount, full, empty, wtime, wtime_valid, reject, underflow
    );
endinterface

// File: rtl/sbqm_param.sv
// Bank-queue manager: synchronised arrival/departure sensing, saturating count,
// and a multi-cycle restoring divider that computes the expected waiting time.
module sbqm_param #(
    parameter int N        = 3,
    parameter int TW       = 2,
    parameter int SVC_TIME = 3,
    parameter int WW       = 5
) (
    input  logic         clk,
    input  logic         reset,
    sbqm_param_if.slave  bus
);
    localparam int WN = N + TW + 2;
    localparam int CW = $clog2(WN + 1);
    localparam logic [N-1:0] PC_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    // Sensor conditioning: index 0 = back (arrival), index 1 = front (departure).
    logic [1:0] w_sens;
    logic [1:0] w_evt;
    assign w_sens = {bus.forwardphoto, bus.backphoto};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic r_s1, r_s2, r_prev;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_prev <= 1'b0;
                end else begin
                    r_s1   <= w_sens[gi];
                    r_s2   <= r_s1;
                    r_prev <= r_s2;
                end
            end
            assign w_evt[gi] = r_s2 & ~r_prev;
        end
    endgenerate

    logic [N-1:0]  r_pc, w_pc_next;
    logic          r_full, r_empty, r_rej, r_und;
    logic          w_rej_next, w_und_next;
    logic [TW-1:0] r_tc;

    always_comb begin
        w_pc_next  = r_pc;
        w_rej_next = 1'b0;
        w_und_next = 1'b0;
        case (w_evt)
            2'b01: begin
                if (r_pc == PC_MAX) w_rej_next = 1'b1;
                else                w_pc_next  = r_pc + N'(1);
            end
            2'b10: begin
                if (r_pc == '0) w_und_next = 1'b1;
                else            w_pc_next  = r_pc - N'(1);
            end
            2'b11: begin
                // Simultaneous events cancel, except that an empty queue takes the arrival.
                if (r_pc == '0) begin
                    w_pc_next  = N'(1);
                    w_und_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_rej   <= 1'b0;
            r_und   <= 1'b0;
            r_tc    <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_full  <= (w_pc_next == PC_MAX);
            r_empty <= (w_pc_next == '0);
            r_rej   <= w_rej_next;
            r_und   <= w_und_next;
            r_tc    <= bus.tcount;
        end
    end

    state_t        r_state, w_state_next;
    logic [N-1:0]  r_pc_l;
    logic [TW-1:0] r_tc_l;
    logic [WN-1:0] r_quo, r_div, w_num;
    logic [WN:0]   r_rem, w_shift, w_trial;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wtime, w_result;
    logic          r_valid;
    logic          w_mismatch, w_latch, w_step, w_publish, w_invalidate, w_sat;

    assign w_mismatch = (r_pc_l != r_pc) || (r_tc_l != r_tc);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_step       = 1'b0;
        w_publish    = 1'b0;
        w_invalidate = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mismatch) begin
                    w_state_next = S_LOAD;
                    w_invalidate = 1'b1;
                end
            end
            S_LOAD: begin
                w_latch      = 1'b1;
                w_state_next = S_DIV;
            end
            S_DIV: begin
                if (w_mismatch) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(1)) w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_mismatch) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_publish    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Numerator wraps when pcount and tc are both zero; that case is overridden in DONE.
    assign w_num   = WN'(SVC_TIME) * (WN'(r_pc) + WN'(r_tc) - WN'(1));
    assign w_shift = {r_rem[WN-1:0], r_quo[WN-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    generate
        if (WN > WW) begin : g_sat
            assign w_sat = |r_quo[WN-1:WW];
        end else begin : g_nosat
            assign w_sat = 1'b0;
        end
    endgenerate

    always_comb begin
        w_result = WW'(r_quo);
        if (r_pc_l == '0)     w_result = '0;
        else if (r_tc_l == '0) w_result = '1;
        else if (w_sat)        w_result = '1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc_l  <= '0;
            r_tc_l  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_wtime <= '0;
            r_valid <= 1'b1;
        end else begin
            if (w_latch) begin
                r_pc_l <= r_pc;
                r_tc_l <= r_tc;
                r_quo  <= w_num;
                r_rem  <= '0;
                r_div  <= WN'(r_tc);
                r_cnt  <= CW'(WN);
            end
            if (w_step) begin
                r_quo <= {r_quo[WN-2:0], ~w_trial[WN]};
                r_rem <= w_trial[WN] ? w_shift : w_trial;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_invalidate) r_valid <= 1'b0;
            if (w_publish) begin
                r_wtime <= w_result;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.pcount      = r_pc;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.reject      = r_rej;
    assign bus.underflow   = r_und;
    assign bus.wtime       = r_wtime;
    assign bus.wtime_valid = r_valid;
endmodule

// File: tb/tb_sbqm_param.sv
// Directed scoreboard bench for sbqm_param: count events, flags, wait-time latency and values.
module tb_sbqm_param;
    localparam int N = 3, TW = 2, WW = 5, SVC = 3, WN = N + TW + 2;
    localparam int PC_MAX = (1 << N) - 1;
    localparam int W_MAX  = (1 << WW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sbqm_param_if #(.N(N), .TW(TW), .WW(WW)) bus ();

    sbqm_param #(.N(N), .TW(TW), .SVC_TIME(SVC), .WW(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int pc;
        bit rej;
        bit und;
    } exp_t;

    exp_t sb_q[$];
    int   wq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_pc  = 0;
    int   m_tc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_wtime(input int pc, input int tc);
        int q;
        if (pc == 0) return 0;
        if (tc == 0) return W_MAX;
        q = SVC * (pc + tc - 1) / tc;
        return (q > W_MAX) ? W_MAX : q;
    endfunction

    // Raise the chosen sensors for three sampled edges; the count must move on the third.
    task automatic pulse(input bit b, input bit f, input string tag);
        exp_t e;
        int   old;
        old   = m_pc;
        e.pc  = m_pc;
        e.rej = 1'b0;
        e.und = 1'b0;
        if (b && !f) begin
            if (m_pc == PC_MAX) e.rej = 1'b1;
            else                e.pc  = m_pc + 1;
        end else if (!b && f) begin
            if (m_pc == 0) e.und = 1'b1;
            else           e.pc  = m_pc - 1;
        end else if (b && f && m_pc == 0) begin
            e.pc  = 1;
            e.und = 1'b1;
        end
        sb_q.push_back(e);
        @(negedge clk);
        bus.backphoto    = b;
        bus.forwardphoto = f;
        repeat (2) begin
            @(posedge clk); #1;
            check({tag, " pcount_early"}, bus.pcount, old);
        end
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check({tag, " pcount"}, bus.pcount, e.pc);
        check({tag, " full"}, bus.full, (e.pc == PC_MAX));
        check({tag, " empty"}, bus.empty, (e.pc == 0));
        check({tag, " reject"}, bus.reject, e.rej);
        check({tag, " underflow"}, bus.underflow, e.und);
        m_pc = e.pc;
        $display("[%0t] %s: back=%0b front=%0b pcount=%0d reject=%0b underflow=%0b",
                 $time, tag, b, f, bus.pcount, bus.reject, bus.underflow);
        bus.backphoto    = 1'b0;
        bus.forwardphoto = 1'b0;
    endtask

    // Called just after an update edge: valid low for WN+2 edges, high with the result on WN+3.
    task automatic check_wait(input string tag);
        int e;
        wq.push_back(exp_wtime(m_pc, m_tc));
        for (int k = 1; k <= WN + 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check({tag, " reject_pulse"}, bus.reject, 0);
                check({tag, " underflow_pulse"}, bus.underflow, 0);
            end
            if (k < WN + 3) begin
                check({tag, " valid_low"}, bus.wtime_valid, 0);
            end else begin
                e = wq.pop_front();
                check({tag, " valid_high"}, bus.wtime_valid, 1);
                check({tag, " wtime"}, bus.wtime, e);
                $display("[%0t] %s: pcount=%0d tcount=%0d wtime=%0d (expected %0d)",
                         $time, tag, m_pc, m_tc, bus.wtime, e);
            end
        end
    endtask

    task automatic idle(input int n, input bit v, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check({tag, " valid"}, bus.wtime_valid, v);
            check({tag, " reject_idle"}, bus.reject, 0);
            check({tag, " underflow_idle"}, bus.underflow, 0);
        end
    endtask

    task automatic set_tc(input int tc);
        @(negedge clk);
        bus.tcount = TW'(tc);
        m_tc = tc;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pcount"}, bus.pcount, 0);
        check({tag, " empty"}, bus.empty, 1);
        check({tag, " full"}, bus.full, 0);
        check({tag, " wtime"}, bus.wtime, 0);
        check({tag, " valid"}, bus.wtime_valid, 1);
        check({tag, " reject"}, bus.reject, 0);
        check({tag, " underflow"}, bus.underflow, 0);
        $display("[%0t] %s: pcount=%0d wtime=%0d valid=%0b", $time, tag,
                 bus.pcount, bus.wtime, bus.wtime_valid);
    endtask

    initial begin
        bus.tcount       = TW'(1);
        bus.backphoto    = 1'b0;
        bus.forwardphoto = 1'b0;
        reset            = 1'b0;

        // Reset state, then the first tc_q load triggers a recompute of 0.
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;
        m_tc  = 1;
        @(posedge clk); #1;
        check_wait("tc_load");

        // Three arrivals; in-flight computations are abandoned, final result 9.
        pulse(1'b1, 1'b0, "arr1");
        idle(5, 1'b0, "gap1");
        pulse(1'b1, 1'b0, "arr2");
        idle(5, 1'b0, "gap2");
        pulse(1'b1, 1'b0, "arr3");
        check_wait("wait_p3_t1");

        // Teller changes, including one that lands while dividing.
        set_tc(3);
        check_wait("wait_p3_t3");
        set_tc(2);
        check_wait("wait_p3_t2");
        set_tc(1);
        idle(4, 1'b0, "mid_div");
        set_tc(3);
        check_wait("restart_p3_t3");

        // Fill to capacity, then reject and simultaneous events at full.
        for (int i = 4; i <= PC_MAX; i++) begin
            pulse(1'b1, 1'b0, "fill");
            check_wait("wait_fill");
        end
        pulse(1'b1, 1'b0, "reject_full");
        idle(3, 1'b1, "after_reject");
        pulse(1'b1, 1'b1, "both_full");
        idle(2, 1'b1, "after_both_full");

        // Drain to empty, underflow, then simultaneous events at empty.
        for (int i = PC_MAX - 1; i >= 0; i--) begin
            pulse(1'b0, 1'b1, "drain");
            check_wait("wait_drain");
        end
        pulse(1'b0, 1'b1, "underflow_empty");
        idle(2, 1'b1, "after_underflow");
        check("empty_wtime", bus.wtime, 0);
        pulse(1'b1, 1'b1, "both_empty");
        check_wait("wait_both_empty");

        // No tellers saturates; then reset aborts a running division.
        pulse(1'b1, 1'b0, "arr_to_2");
        check_wait("wait_p2_t3");
        set_tc(0);
        check_wait("wait_p2_t0");
        set_tc(1);
        idle(3, 1'b0, "div_before_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        m_pc = 0;
        check_reset_state("reset_mid_div");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_wait("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
